io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the shared 16-bit bidirectional I/O bus of the basic CPU.
//  Grants one of NREQ requesters (CPU load/store unit, DMA, debug port...) per transfer,
//  runs the SETUP/STROBE/DONE bus cycle and drives the external transceiver's oe.
//  Peripheral side: addr/we/strobe out, ready in; data via the transceiver (dout -> in, din <- out).
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  ADDR_W   8   I/O address width
//  DATA_W   16  bus data width
//  TIMEOUT  15  max STROBE cycles waiting for bus_rdy before error (1..255)
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  reset      in   1              asynchronous, active-high
//  req        in   NREQ           req[i]=1: requester i wants a transfer; hold until ack[i]
//  req_we     in   NREQ           req_we[i]=1 write, 0 read (sampled with req)
//  req_addr   in   NREQ*ADDR_W    requester i address in slice [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NREQ*DATA_W    requester i write data in slice [i*DATA_W +: DATA_W]
//  ack        out  NREQ           one-hot, 1-cycle pulse: transfer for requester i finished
//  err        out  1              valid with ack: 1 = timeout, transfer aborted
//  rdata      out  DATA_W         read data, valid with ack on a successful read
//  gnt        out  NREQ           one-hot owner of the bus, SETUP..DONE inclusive
//  bus_addr   out  ADDR_W         latched address of granted requester
//  bus_we     out  1              latched direction
//  bus_stb    out  1              strobe, high in STROBE state only
//  bus_oe     out  1              transceiver oe: high in SETUP and STROBE when bus_we=1
//  bus_dout   out  DATA_W         latched write data to transceiver in
//  bus_din    in   DATA_W         transceiver out (bus value)
//  bus_rdy    in   1              peripheral completes the access, sampled in STROBE
// BEHAVIOUR
//  Reset: state=IDLE; ack,gnt,err,bus_stb,bus_oe,bus_we=0; bus_addr,bus_dout,rdata=0;
//   rr pointer last=NREQ-1 (req[0] wins first); timeout counter=0. Reset mid-transfer aborts
//   immediately, no ack is issued.
//  FSM: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
//  IDLE: if any req: winner = first set req scanning last+1, last+2, .. wrapping mod NREQ;
//   latch winner's addr/we/wdata, gnt<=onehot(winner), last<=winner, go SETUP. Else stay.
//  SETUP (exactly 1 cycle): bus signals stable, bus_stb=0, counter<=0; go STROBE.
//  STROBE: bus_stb=1. If bus_rdy: rdata<=bus_din when read (unchanged on write), err<=0,
//   go DONE. Else if counter==TIMEOUT-1: err<=1, go DONE (rdata unchanged). Else counter+1.
//  DONE (1 cycle): ack[winner]=1, bus_stb=0, bus_oe=0, gnt still held; go IDLE; gnt<=0.
//  Latency: req seen in IDLE cycle T, bus_rdy high in first STROBE cycle -> ack in cycle T+3.
//   Back-to-back transfers: one IDLE cycle between DONE and next SETUP (4 cycles/transfer min).
//  Requester rule: drop req on the edge ending its ack cycle; req still high in the next
//   IDLE is a new request. Dropping req after grant does not cancel the transfer.
//  req/req_we/addr/wdata of non-granted or already-latched requesters are ignored until IDLE.
//  bus_rdy outside STROBE is ignored. Only one ack bit ever high; err=0 whenever ack=0.
//  Fairness: with all req held high, grant order is 0,1,..,NREQ-1,0,.. (no starvation).
// TESTING
//  1 Reset then req=0001 read addr 0x10, bus_rdy=1 first STROBE cycle, bus_din=0xBEEF
//    -> ack=0001 3 cycles later, rdata=0xBEEF, err=0, bus_oe never high.
//  2 req[2] write addr 0x22 wdata 0x1234, rdy after 3 STROBE cycles -> bus_oe=1 and
//    bus_dout=0x1234 during SETUP+STROBE, bus_stb high 3 cycles, ack=0100, rdata unchanged.
//  3 req=1111 held, rdy immediate -> gnt order 0,1,2,3,0; acks 4 cycles apart.
//  4 req[1] read, bus_rdy never -> bus_stb high exactly TIMEOUT=15 cycles, ack=0010 with err=1.
//  5 reset pulsed during STROBE of a write -> all outputs 0 asynchronously, no ack; next
//    req=0100 alone -> granted requester 2 normally.
//  6 req[3] dropped one cycle after gnt=1000 -> transfer still completes, ack=1000.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Round-robin arbiter and bus-cycle sequencer for the shared bidirectional
//   I/O bus. In each transfer it grants one requester, then runs the bus
//   cycle SETUP -> STROBE -> DONE and drives the transceiver output enable.
//
// Ports
//   clk, reset            clock (rising edge); asynchronous active-high reset
//   req, req_we           per-requester request and direction (1 = write)
//   req_addr, req_wdata   per-requester address/data, slice i holds requester i
//   ack, err, rdata       one-hot completion pulse, timeout flag, read data
//   gnt                   one-hot bus owner, held from SETUP through DONE
//   bus_addr, bus_we      latched address and direction of the current owner
//   bus_stb, bus_oe       strobe (STROBE only), transceiver oe (write, SETUP+STROBE)
//   bus_dout, bus_din     write data to the transceiver, bus value from it
//   bus_rdy               peripheral completion, only looked at during STROBE
module io_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          gnt,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic                     bus_we,
  output logic                     bus_stb,
  output logic                     bus_oe,
  output logic [DATA_W-1:0]        bus_dout,
  input  logic [DATA_W-1:0]        bus_din,
  input  logic                     bus_rdy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] winner_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;
  logic             timeout_s;
  logic [7:0]       cnt_r;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin scan: the requester right after the previous winner has top priority.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_r;
    idx_s    = last_r;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IDX_W'((int'(last_r) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state logic of the bus-cycle sequencer.
  always_comb begin
    state_s   = state_r;
    timeout_s = (cnt_r == 8'(TIMEOUT - 1));
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_s = ST_STROBE;
      ST_STROBE: begin
        // bus_rdy wins over a timeout that lands in the same cycle
        if (bus_rdy || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered bus outputs, latched transfer parameters, timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      gnt      <= '0;
      bus_addr <= '0;
      bus_we   <= 1'b0;
      bus_stb  <= 1'b0;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      cnt_r    <= 8'd0;
      last_r   <= IDX_W'(NREQ - 1);
    end else begin
      // ack/err are single-cycle pulses
      ack <= '0;
      err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            bus_addr <= req_addr[int'(winner_s)*ADDR_W +: ADDR_W];
            bus_dout <= req_wdata[int'(winner_s)*DATA_W +: DATA_W];
            bus_we   <= req_we[winner_s];
            bus_oe   <= req_we[winner_s];
            gnt      <= onehot(winner_s);
            last_r   <= winner_s;
          end
        end
        ST_SETUP: begin
          cnt_r   <= 8'd0;
          bus_stb <= 1'b1;
        end
        ST_STROBE: begin
          if (bus_rdy) begin
            if (!bus_we) begin
              rdata <= bus_din;
            end
            bus_stb <= 1'b0;
            bus_oe  <= 1'b0;
            ack     <= gnt;
          end else if (timeout_s) begin
            bus_stb <= 1'b0;
            bus_oe  <= 1'b0;
            ack     <= gnt;
            err     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          gnt <= '0;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Random requesters and a random peripheral drive io_bus_arbiter. A
//   transfer-schedule model predicts every output each cycle: a grant made in
//   an idle cycle c opens a transfer whose SETUP is cycle c+1, followed by L
//   strobe cycles (L = rdy delay, capped at TIMEOUT) and one DONE cycle.
module tb_io_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      bus_addr;
  logic                   bus_we;
  logic                   bus_stb;
  logic                   bus_oe;
  logic [DATA_W-1:0]      bus_dout;
  logic [DATA_W-1:0]      bus_din;
  logic                   bus_rdy;

  io_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .gnt(gnt),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_stb(bus_stb), .bus_oe(bus_oe),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // requester agents
  logic              a_we    [NREQ];
  logic [ADDR_W-1:0] a_addr  [NREQ];
  logic [DATA_W-1:0] a_wdata [NREQ];

  // transfer schedule model
  int                cyc;
  bit                act;
  int                s, len, d, own, last;
  bit                cur_we, cur_to;
  logic [ADDR_W-1:0] e_addr;
  logic              e_we;
  logic [DATA_W-1:0] e_dout, e_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    act     = 1'b0;
    s       = 0;
    len     = 0;
    d       = 0;
    own     = 0;
    last    = NREQ - 1;
    cur_we  = 1'b0;
    cur_to  = 1'b0;
    e_addr  = '0;
    e_we    = 1'b0;
    e_dout  = '0;
    e_rdata = '0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_ack"},   32'(ack),      32'd0);
    chk({tag, "_err"},   32'(err),      32'd0);
    chk({tag, "_gnt"},   32'(gnt),      32'd0);
    chk({tag, "_stb"},   32'(bus_stb),  32'd0);
    chk({tag, "_oe"},    32'(bus_oe),   32'd0);
    chk({tag, "_we"},    32'(bus_we),   32'd0);
    chk({tag, "_addr"},  32'(bus_addr), 32'd0);
    chk({tag, "_dout"},  32'(bus_dout), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata),    32'd0);
  endtask

  task automatic check_outputs();
    int              off;
    bit              a;
    logic [NREQ-1:0] oh;
    off = cyc - s;
    a   = act && off >= 0 && off <= len + 1;
    oh  = '0;
    if (a) oh[own] = 1'b1;
    chk("gnt",   32'(gnt),      32'(oh));
    chk("ack",   32'(ack),      32'((a && off == len + 1) ? oh : '0));
    chk("err",   32'(err),      32'(a && off == len + 1 && cur_to));
    chk("stb",   32'(bus_stb),  32'(a && off >= 1 && off <= len));
    chk("oe",    32'(bus_oe),   32'(a && cur_we && off <= len));
    chk("addr",  32'(bus_addr), 32'(e_addr));
    chk("we",    32'(bus_we),   32'(e_we));
    chk("dout",  32'(bus_dout), 32'(e_dout));
    chk("rdata", 32'(rdata),    32'(e_rdata));
  endtask

  // Drive inputs for the current cycle and advance the schedule model.
  task automatic drive_and_model(input bit allow_new);
    int off;
    bit a;
    bit found;
    int r;
    off = cyc - s;
    a   = act && off >= 0 && off <= len + 1;
    if (a && off == len + 1) begin
      req[own] = 1'b0;                       // drop on the ack cycle
    end else if (a && off <= len && req[own] && $urandom_range(0, 5) == 0) begin
      req[own] = 1'b0;                       // early drop must not cancel
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i] || (a && i == own)) begin
        a_we[i]    = 1'($urandom_range(0, 1));
        a_addr[i]  = ADDR_W'($urandom);
        a_wdata[i] = DATA_W'($urandom);
      end
      if (allow_new && !req[i] && !(a && i == own) && $urandom_range(0, 2) == 0)
        req[i] = 1'b1;
      req_we[i]                       = a_we[i];
      req_addr[i*ADDR_W +: ADDR_W]    = a_addr[i];
      req_wdata[i*DATA_W +: DATA_W]   = a_wdata[i];
    end
    bus_din = DATA_W'($urandom);
    if (a && off >= 1 && off <= len) bus_rdy = (off == d);
    else                             bus_rdy = 1'($urandom_range(0, 1));
    if (a && off == d && !cur_we) e_rdata = bus_din;
    if (!a && req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(last + k) % NREQ]) begin
          own   = (last + k) % NREQ;
          found = 1'b1;
        end
      end
      last   = own;
      act    = 1'b1;
      s      = cyc + 1;
      cur_we = a_we[own];
      e_we   = a_we[own];
      e_addr = a_addr[own];
      e_dout = a_wdata[own];
      r = $urandom_range(0, 9);
      if (r < 2)      d = TIMEOUT + 5;
      else if (r < 4) d = $urandom_range(1, TIMEOUT);
      else            d = $urandom_range(1, 3);
      len    = (d > TIMEOUT) ? TIMEOUT : d;
      cur_to = (d > TIMEOUT);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
    drive_and_model(1'b1);
  endtask

  initial begin
    bit found;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_din   = '0;
    bus_rdy   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_we[i]    = 1'b0;
      a_addr[i]  = '0;
      a_wdata[i] = '0;
    end
    cyc = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check_reset_zero("init");
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    check_outputs();
    drive_and_model(1'b1);

    repeat (800) step();

    // run until a write is in its strobe phase, then reset asynchronously
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (act && cur_we && (cyc - s) >= 1 && (cyc - s) <= len) found = 1'b1;
    end
    chk("rst_window", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1 check_reset_zero("mid");
    req = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    check_outputs();
    req[2]     = 1'b1;
    a_we[2]    = 1'($urandom_range(0, 1));
    a_addr[2]  = ADDR_W'($urandom);
    a_wdata[2] = DATA_W'($urandom);
    drive_and_model(1'b0);
    chk("post_rst_winner", 32'(own), 32'd2);

    repeat (600) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
